pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ctrl_pkg.sv | 11 +
 rtl/step_divider.sv | 47 ++++
 rtl/pwm_ramp_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller.
//   state_e : ramp FSM state encoding (IDLE / UP / DOWN)
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

endpackage : pwm_ctrl_pkg

// File: rtl/step_divider.sv
// Step prescaler: free-running counter 0..prescale that emits a one-cycle
// tick at terminal count. Holds its count while enable is low.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   enable   : run/freeze control
//   prescale : terminal count (step period minus one), sampled at every compare
//   tick     : one-cycle strobe at terminal count
module step_divider #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [PW-1:0] prescale,
  output logic          tick
);

  localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] cnt_r;
  logic          hit_s;

  // Terminal-count detect; the strobe is held low while disabled or in reset.
  always_comb begin
    hit_s = 1'b0;
    if (cnt_r == prescale) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    tick = enable & rst & hit_s;
  end

  // Prescale counter: freeze when disabled, wrap to zero at terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {PW{1'b0}};
    end else if (!enable) begin
      cnt_r <= cnt_r;
    end else if (hit_s) begin
      cnt_r <= {PW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

endmodule : step_divider

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller. Accepts a (target, rate) request in IDLE and
// walks pwm_duty one LSB at a time toward the target, one change per
// (cfg_rate+1) step strobes. Duty never wraps: it only moves toward target.
//   clk, rst   : system clock / asynchronous active-low reset
//   enable     : run/freeze; mirrored on pwm_ena, gates the step strobe
//   prescale   : step period minus one, in clk cycles
//   cfg_*      : valid/ready ramp request (target duty, rate)
//   pwm_ena    : PWM enable (combinational copy of enable)
//   pwm_step   : one-cycle counter-advance strobe
//   pwm_duty   : registered duty
//   busy       : ramp in progress (UP or DOWN)
//   done       : one-cycle pulse when a ramp completes
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = 16,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [PW-1:0] prescale,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_target,
  input  logic [RW-1:0] cfg_rate,
  output logic          pwm_ena,
  output logic          pwm_step,
  output logic [N-1:0]  pwm_duty,
  output logic          busy,
  output logic          done
);

  localparam logic [N-1:0]  DUTY_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] RATE_ONE = {{(RW-1){1'b0}}, 1'b1};

  state_e        state_r,  state_nx_s;
  logic [N-1:0]  duty_r,   duty_nx_s;
  logic [N-1:0]  target_r, target_nx_s;
  logic [RW-1:0] rate_r,   rate_nx_s;
  logic [RW-1:0] rcnt_r,   rcnt_nx_s;
  logic          done_r,   done_nx_s;
  logic          tick_s;
  logic [N-1:0]  duty_inc_s;
  logic [N-1:0]  duty_dec_s;

  step_divider #(.PW(PW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick_s)
  );

  // Output decode from registered state.
  always_comb begin
    pwm_ena   = enable;
    pwm_step  = tick_s;
    pwm_duty  = duty_r;
    done      = done_r;
    cfg_ready = (state_r == ST_IDLE);
    busy      = (state_r == ST_UP) || (state_r == ST_DOWN);
  end

  // Next-state, duty and request-latch decode.
  always_comb begin
    state_nx_s  = state_r;
    duty_nx_s   = duty_r;
    target_nx_s = target_r;
    rate_nx_s   = rate_r;
    rcnt_nx_s   = rcnt_r;
    done_nx_s   = 1'b0;
    duty_inc_s  = duty_r + DUTY_ONE;
    duty_dec_s  = duty_r - DUTY_ONE;
    case (state_r)
      ST_IDLE: begin
        // Requests are taken even while disabled; only the ramp itself freezes.
        if (cfg_valid) begin
          target_nx_s = cfg_target;
          rate_nx_s   = cfg_rate;
          rcnt_nx_s   = {RW{1'b0}};
          if (cfg_target > duty_r) begin
            state_nx_s = ST_UP;
          end else if (cfg_target < duty_r) begin
            state_nx_s = ST_DOWN;
          end else begin
            done_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_UP: begin
        if (!tick_s) begin
          state_nx_s = ST_UP;
        end else if (rcnt_r != rate_r) begin
          rcnt_nx_s = rcnt_r + RATE_ONE;
        end else if (duty_r < target_r) begin
          rcnt_nx_s = {RW{1'b0}};
          duty_nx_s = duty_inc_s;
          if (duty_inc_s == target_r) begin
            state_nx_s = ST_IDLE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_UP;
          end
        end else begin
          // Already at target: finish without moving, so the top bound holds.
          rcnt_nx_s  = {RW{1'b0}};
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
        end
      end
      ST_DOWN: begin
        if (!tick_s) begin
          state_nx_s = ST_DOWN;
        end else if (rcnt_r != rate_r) begin
          rcnt_nx_s = rcnt_r + RATE_ONE;
        end else if (duty_r > target_r) begin
          rcnt_nx_s = {RW{1'b0}};
          duty_nx_s = duty_dec_s;
          if (duty_dec_s == target_r) begin
            state_nx_s = ST_IDLE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_DOWN;
          end
        end else begin
          // Already at target: finish without moving, so zero holds.
          rcnt_nx_s  = {RW{1'b0}};
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        rcnt_nx_s  = {RW{1'b0}};
      end
    endcase
  end

  // State, duty, latched request and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      duty_r   <= {N{1'b0}};
      target_r <= {N{1'b0}};
      rate_r   <= {RW{1'b0}};
      rcnt_r   <= {RW{1'b0}};
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      duty_r   <= duty_nx_s;
      target_r <= target_nx_s;
      rate_r   <= rate_nx_s;
      rcnt_r   <= rcnt_nx_s;
      done_r   <= done_nx_s;
    end
  end

endmodule : pwm_ramp_ctrl

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl. Stimulus pushes the expected ramp
// (every intermediate duty value, then the done) into a queue; a monitor on
// the falling edge pops and compares whenever the DUT changes duty or pulses
// done, and checks step spacing against the prescale rule.
module tb_pwm_ramp_ctrl;
  localparam int N  = 8;
  localparam int PW = 16;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [N-1:0]  cfg_target = '0;
  logic [RW-1:0] cfg_rate = '0;
  logic          pwm_ena, pwm_step, busy, done;
  logic [N-1:0]  pwm_duty;

  pwm_ramp_ctrl #(.N(N), .PW(PW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .prescale(prescale),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_target(cfg_target),
    .cfg_rate(cfg_rate), .pwm_ena(pwm_ena), .pwm_step(pwm_step),
    .pwm_duty(pwm_duty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int val;
    int ticks;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  m_duty = 0;
  int  last_seen = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int  prev_duty = 0;
  int  tick_cnt = 0;
  int  en_cyc = 0;
  ev_t e;
  bit  busy_exp;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_duty", int'(pwm_duty), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(cfg_ready), 1);
      chk("rst_step", int'(pwm_step), 0);
      prev_duty = 0; tick_cnt = 0; en_cyc = 0; last_seen = 0;
    end else begin
      chk("pwm_ena", int'(pwm_ena), int'(enable));
      if (int'(pwm_duty) != prev_duty) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL duty_unexpected: got %0d expected %0d at %0t", pwm_duty, prev_duty, $time);
        end else begin
          e = exp_q.pop_front();
          chk("duty_val", int'(pwm_duty), e.val);
          chk("duty_ticks", tick_cnt, e.ticks);
        end
        prev_duty = int'(pwm_duty);
        last_seen = prev_duty;
        tick_cnt = 0;
      end
      if (done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got 1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("done_duty", int'(pwm_duty), e.val);
        end
      end
      busy_exp = (exp_q.size() > 0) && !exp_q[0].is_done;
      chk("busy", int'(busy), int'(busy_exp));
      chk("cfg_ready", int'(cfg_ready), int'(!busy_exp));
      if (!enable) chk("step_gated", int'(pwm_step), 0);
      if (busy_exp && pwm_step) tick_cnt++;
      if (enable) en_cyc++;
      if (pwm_step) begin
        chk("step_period", en_cyc, int'(prescale) + 1);
        en_cyc = 0;
      end else if (en_cyc > int'(prescale) + 1) begin
        checks++; errors++;
        $display("FAIL step_missing: got %0d enabled cycles expected %0d", en_cyc, int'(prescale) + 1);
        en_cyc = 0;
      end
    end
  end

  // ---------------- stimulus helpers (drive 2ns after rising edge) ----------------
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset(int p);
    exp_q.delete();
    cfg_valid = 1'b0;
    rst = 1'b0;
    prescale = PW'(p);
    cyc(2);
    rst = 1'b1;
    m_duty = 0;
  endtask

  // Issue one request while the model is idle and queue its expected ramp.
  task automatic request(int t, int r);
    cfg_target = N'(t);
    cfg_rate = RW'(r);
    cfg_valid = 1'b1;
    cyc(1);
    cfg_valid = 1'b0;
    if (t > m_duty) begin
      for (int v = m_duty + 1; v <= t; v++) exp_q.push_back('{1'b0, v, r + 1});
    end else if (t < m_duty) begin
      for (int v = m_duty - 1; v >= t; v--) exp_q.push_back('{1'b0, v, r + 1});
    end
    exp_q.push_back('{1'b1, t, 0});
    m_duty = t;
  endtask

  // Wait for the queue to drain; optionally jitter enable and send ignored requests.
  task automatic wait_idle(int budget, bit jitter);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (jitter) begin
        enable = ($urandom_range(0, 3) != 0);
        if (exp_q.size() > 2 && $urandom_range(0, 3) == 0) begin
          cfg_valid = 1'b1;
          cfg_target = N'($urandom_range(0, 255));
          cfg_rate = RW'($urandom_range(0, 3));
        end else begin
          cfg_valid = 1'b0;
        end
      end
      cyc(1);
      n++;
    end
    cfg_valid = 1'b0;
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL ramp_timeout: got %0d pending events expected 0", exp_q.size());
      do_reset(int'(prescale));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t, n;
    // Reset values, prescale=3 step spacing, and a 5-cycle freeze.
    enable = 1'b1;
    prescale = 16'd3;
    #1 rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(14);
    enable = 1'b0;
    cyc(5);
    enable = 1'b1;
    cyc(14);

    // 0 -> 5, rate 0, prescale 0: one change per cycle.
    do_reset(0);
    request(5, 0);
    wait_idle(50, 1'b0);
    cyc(3);

    // 5 -> 2, rate 2, prescale 1: one change per six cycles.
    do_reset(1);
    request(5, 0);
    wait_idle(100, 1'b0);
    request(2, 2);
    wait_idle(100, 1'b0);
    cyc(3);

    // Equal target at duty 7: done only, never busy; also with enable low.
    request(7, 0);
    wait_idle(100, 1'b0);
    request(7, 3);
    wait_idle(20, 1'b0);
    enable = 1'b0;
    request(7, 1);
    wait_idle(20, 1'b0);
    enable = 1'b1;
    cyc(2);

    // Held cfg_valid during a ramp is ignored; top bound stops at 255.
    do_reset(0);
    request(250, 0);
    wait_idle(600, 1'b0);
    request(255, 1);
    cfg_target = 8'd10;
    cfg_rate = 8'd0;
    cfg_valid = 1'b1;
    n = 0;
    while (exp_q.size() > 2 && n < 100) begin cyc(1); n++; end
    cfg_valid = 1'b0;
    wait_idle(100, 1'b0);
    request(255, 0);
    wait_idle(20, 1'b0);
    cyc(6);

    // Reset mid-ramp at duty 3, then new ramps up and down to zero.
    do_reset(2);
    request(9, 0);
    n = 0;
    while (last_seen != 3 && n < 100) begin cyc(1); n++; end
    chk("abort_point", last_seen, 3);
    do_reset(2);
    cyc(4);
    request(4, 1);
    wait_idle(200, 1'b0);
    request(0, 0);
    wait_idle(200, 1'b0);
    cyc(4);

    // Randomized ramps with enable jitter and ignored requests.
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) begin
        enable = 1'b1;
        do_reset(int'($urandom_range(0, 3)));
      end
      t = m_duty + int'($urandom_range(0, 24)) - 12;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      request(t, int'($urandom_range(0, 3)));
      wait_idle(3000, 1'b1);
    end
    enable = 1'b1;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule : tb_pwm_ramp_ctrl
